// File: rtl/gram_burst_sched.sv
// SDRAM burst scheduler between the CMOS write FIFO, the VGA read FIFO and sdram_core.
// Optional write-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module gram_burst_sched #(
   parameter int BURST_LEN      = 256,
   parameter int LVL_W          = 9,
   parameter int ROW_W          = 13,
   parameter int COL_W          = 9,
   parameter int ROWS_PER_FRAME = 1875,
   parameter int MAX_RD_STREAK  = 4,
   parameter int BUSY_TIMEOUT   = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init_done,
   input  logic [LVL_W-1:0]         in_level,
   input  logic [LVL_W-1:0]         out_level,
   input  logic                     wr_busy,
   input  logic                     rd_busy,
   output logic                     wr_req,
   output logic                     rd_req,
   output logic [2+ROW_W+COL_W-1:0] wr_addr,
   output logic [2+ROW_W+COL_W-1:0] rd_addr,
   output logic                     wr_frame,
   output logic                     rd_frame,
   output logic                     err
);
   localparam int               TO_W      = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [LVL_W:0]   BURST_LVL = (LVL_W+1)'(BURST_LEN);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS_PER_FRAME - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE_WR, WAIT_WR_RISE, WAIT_WR_FALL, ISSUE_RD, WAIT_RD_RISE, WAIT_RD_FALL
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       wr_busy_sh, rd_busy_sh;  // [0] current sample, [1] previous
   logic             wr_rise, wr_fall, rd_rise, rd_fall;
   logic             wr_need, rd_need, guarded, busy_idle;
   logic             grant_wr, grant_rd, adv_wr, adv_rd, timeout;
   logic [TO_W-1:0]  to_cnt;
   logic [1:0]       wr_bank, rd_bank;
   logic [ROW_W-1:0] wr_row, rd_row;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_busy_sh <= '0;
         rd_busy_sh <= '0;
      end else begin
         wr_busy_sh <= {wr_busy_sh[0], wr_busy};
         rd_busy_sh <= {rd_busy_sh[0], rd_busy};
      end
   end

   assign wr_rise   = ~wr_busy_sh[1] &  wr_busy_sh[0];
   assign wr_fall   =  wr_busy_sh[1] & ~wr_busy_sh[0];
   assign rd_rise   = ~rd_busy_sh[1] &  rd_busy_sh[0];
   assign rd_fall   =  rd_busy_sh[1] & ~rd_busy_sh[0];
   assign busy_idle = ~wr_busy_sh[0] & ~rd_busy_sh[0];
   assign wr_need   = {1'b0, in_level} >= BURST_LVL;
   assign rd_need   = {1'b0, out_level} < BURST_LVL;

`ifdef ARB_STARVE_GUARD_EN
   localparam int              STK_W   = $clog2(MAX_RD_STREAK + 1);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_RD_STREAK);
   logic [STK_W-1:0] streak;

   assign guarded = (streak >= STK_MAX) && wr_need;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              streak <= '0;
      else if (grant_wr)                    streak <= '0;
      else if (grant_rd && streak != STK_MAX) streak <= streak + 1'b1;
   end
`else
   // Strict read priority: a guard can never fire.
   assign guarded = (MAX_RD_STREAK < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      adv_wr   = 1'b0;
      adv_rd   = 1'b0;
      timeout  = 1'b0;
      case (state)
         IDLE: begin
            if (init_done && busy_idle) begin
               if (rd_need && !guarded) begin
                  grant_rd = 1'b1;
                  state_nx = ISSUE_RD;
               end else if (wr_need) begin
                  grant_wr = 1'b1;
                  state_nx = ISSUE_WR;
               end
            end
         end
         ISSUE_WR: state_nx = WAIT_WR_RISE;
         WAIT_WR_RISE: begin
            if (wr_rise) state_nx = WAIT_WR_FALL;
            else if (to_cnt == TO_LAST) begin
               timeout  = 1'b1;
               state_nx = IDLE;
            end
         end
         WAIT_WR_FALL: begin
            if (wr_fall) begin
               adv_wr   = 1'b1;
               state_nx = IDLE;
            end
         end
         ISSUE_RD: state_nx = WAIT_RD_RISE;
         WAIT_RD_RISE: begin
            if (rd_rise) state_nx = WAIT_RD_FALL;
            else if (to_cnt == TO_LAST) begin
               timeout  = 1'b1;
               state_nx = IDLE;
            end
         end
         WAIT_RD_FALL: begin
            if (rd_fall) begin
               adv_rd   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign wr_req = (state == ISSUE_WR);
   assign rd_req = (state == ISSUE_RD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) to_cnt <= '0;
      else if (state == ISSUE_WR || state == ISSUE_RD) to_cnt <= '0;
      else if ((state == WAIT_WR_RISE || state == WAIT_RD_RISE) && to_cnt != TO_LAST)
         to_cnt <= to_cnt + 1'b1;
   end

   // Read bank only follows the writer once the writer has moved on, so a
   // slow writer makes the reader replay the last complete frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank  <= 2'b00;
         rd_bank  <= 2'b11;
         wr_row   <= '0;
         rd_row   <= '0;
         wr_frame <= 1'b0;
         rd_frame <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_frame <= 1'b0;
         rd_frame <= 1'b0;
         if (timeout) err <= 1'b1;
         if (adv_wr) begin
            if (wr_row == LAST_ROW) begin
               wr_row   <= '0;
               wr_bank  <= ~wr_bank;
               wr_frame <= 1'b1;
            end else begin
               wr_row <= wr_row + 1'b1;
            end
         end
         if (adv_rd) begin
            if (rd_row == LAST_ROW) begin
               rd_row   <= '0;
               rd_frame <= 1'b1;
               if (rd_bank == wr_bank) rd_bank <= ~rd_bank;
            end else begin
               rd_row <= rd_row + 1'b1;
            end
         end
      end
   end

   assign wr_addr = {wr_bank, wr_row, {COL_W{1'b0}}};
   assign rd_addr = {rd_bank, rd_row, {COL_W{1'b0}}};

endmodule

// File: tb/tb_gram_burst_sched.sv
// Randomized bench for gram_burst_sched against a transaction-level model of
// arbitration, ping-pong addressing, frame pulses and busy timeout.
module tb_gram_burst_sched;
   localparam int LVL_W = 9, ROW_W = 13, COL_W = 9, RPF = 3, MRS = 4, BT = 32, BL = 256;
   localparam int AW = 2 + ROW_W + COL_W;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic             clk = 1'b0, rst = 1'b1, init_done = 1'b0;
   logic [LVL_W-1:0] in_level = 9'd300, out_level = 9'd300;
   logic             wr_busy = 1'b0, rd_busy = 1'b0;
   logic             wr_req, rd_req, wr_frame, rd_frame, err;
   logic [AW-1:0]    wr_addr, rd_addr;

   gram_burst_sched #(
      .BURST_LEN(BL), .LVL_W(LVL_W), .ROW_W(ROW_W), .COL_W(COL_W),
      .ROWS_PER_FRAME(RPF), .MAX_RD_STREAK(MRS), .BUSY_TIMEOUT(BT)
   ) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .in_level(in_level),
      .out_level(out_level), .wr_busy(wr_busy), .rd_busy(rd_busy),
      .wr_req(wr_req), .rd_req(rd_req), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .wr_frame(wr_frame), .rd_frame(rd_frame), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   typedef struct { bit is_wr; bit is_rd; logic [AW-1:0] addr; int cyc; } ev_t;
   ev_t evq[$];
   int  cyc = 0, wr_fr = 0, rd_fr = 0;
   bit  pwr = 1'b0, prd = 1'b0;

   // request / frame-pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (pwr) chk("wr_req_width", 64'(wr_req), 64'd0);
      if (prd) chk("rd_req_width", 64'(rd_req), 64'd0);
      if (wr_req || rd_req) begin
         e.is_wr = wr_req;
         e.is_rd = rd_req;
         e.addr  = wr_req ? wr_addr : rd_addr;
         e.cyc   = cyc;
         evq.push_back(e);
      end
      pwr = wr_req;
      prd = rd_req;
      wr_fr += int'(wr_frame);
      rd_fr += int'(rd_frame);
   end

   // reference model state
   int m_wr_row, m_rd_row, m_wr_bank, m_rd_bank, m_streak, last_cyc;
   bit m_err;

   task automatic model_reset();
      m_wr_row = 0; m_rd_row = 0; m_wr_bank = 0; m_rd_bank = 3;
      m_streak = 0; m_err = 1'b0; last_cyc = -100;
   endtask

   function automatic logic [AW-1:0] mk_addr(input int bank, input int row);
      logic [AW-1:0] a;
      a = '0;
      a[AW-1 -: 2]      = bank[1:0];
      a[COL_W +: ROW_W] = row[ROW_W-1:0];
      return a;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // 0: no grant, 1: write, 2: read
   task automatic decide(output int k);
      bit rn, wn, g;
      rn = int'(out_level) < BL;
      wn = int'(in_level) >= BL;
      g  = GUARD && (m_streak >= MRS) && wn;
      if (rn && !g) begin
         k = 2;
         if (m_streak < MRS) m_streak++;
      end else if (wn) begin
         k = 1;
         m_streak = 0;
      end else k = 0;
   endtask

   // One scheduling decision; nin/nout are the levels presented for the next one.
   task automatic run_burst(input bit to_mode, input int nin, input int nout,
                            input int blen, output int seen);
      int k, n, d, len, wf0, rf0;
      bit last;
      ev_t e;
      logic [AW-1:0] ea;
      seen = 0;
      decide(k);
      if (k == 0) begin
         repeat (20) step();
         chk("idle_noreq", 64'(evq.size()), 64'd0);
         in_level = LVL_W'(nin); out_level = LVL_W'(nout);
         return;
      end
      n = 0;
      while (evq.size() == 0 && n < 60) begin step(); n++; end
      if (evq.size() == 0) begin
         chk("req_missing", 64'd0, 64'd1);
         return;
      end
      e = evq.pop_front();
      seen = e.is_wr ? 1 : (e.is_rd ? 2 : 0);
      ea = (k == 1) ? mk_addr(m_wr_bank, m_wr_row) : mk_addr(m_rd_bank, m_rd_row);
      chk("req_kind", 64'({e.is_wr, e.is_rd}), (k == 1) ? 64'd2 : 64'd1);
      chk("req_addr", 64'(e.addr), 64'(ea));
      chk("req_gap", 64'((e.cyc - last_cyc) >= 4), 64'd1);
      last_cyc = e.cyc;
      in_level = LVL_W'(nin); out_level = LVL_W'(nout);
      if (to_mode) begin
         repeat (BT + 6) step();
         m_err = 1'b1;
         chk("err_timeout", 64'(err), 64'd1);
         chk("to_wr_addr", 64'(wr_addr), 64'(mk_addr(m_wr_bank, m_wr_row)));
         chk("to_rd_addr", 64'(rd_addr), 64'(mk_addr(m_rd_bank, m_rd_row)));
         return;
      end
      d = $urandom_range(1, 4);
      repeat (d) step();
      len = (blen > 0) ? blen : int'($urandom_range(2, 12));
      if (k == 1) wr_busy = 1'b1; else rd_busy = 1'b1;
      repeat (len) begin
         step();
         chk("addr_hold", (k == 1) ? 64'(wr_addr) : 64'(rd_addr), 64'(ea));
      end
      wf0 = wr_fr; rf0 = rd_fr;
      wr_busy = 1'b0; rd_busy = 1'b0;
      repeat (6) step();
      if (k == 1) begin
         last = (m_wr_row == RPF - 1);
         if (last) begin m_wr_row = 0; m_wr_bank ^= 3; end
         else m_wr_row++;
      end else begin
         last = (m_rd_row == RPF - 1);
         if (last) begin
            m_rd_row = 0;
            if (m_rd_bank == m_wr_bank) m_rd_bank ^= 3;
         end else m_rd_row++;
      end
      chk("wr_frame", 64'(wr_fr - wf0), 64'(k == 1 && last));
      chk("rd_frame", 64'(rd_fr - rf0), 64'(k == 2 && last));
      chk("wr_addr_adv", 64'(wr_addr), 64'(mk_addr(m_wr_bank, m_wr_row)));
      chk("rd_addr_adv", 64'(rd_addr), 64'(mk_addr(m_rd_bank, m_rd_row)));
      chk("err_state", 64'(err), 64'(m_err));
   endtask

   function automatic int pick_lvl();
      int t[6] = '{0, 100, 255, 256, 300, 511};
      return t[$urandom_range(0, 5)];
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr_req"},   64'(wr_req),   64'd0);
      chk({tag, "_rd_req"},   64'(rd_req),   64'd0);
      chk({tag, "_wr_addr"},  64'(wr_addr),  64'(mk_addr(0, 0)));
      chk({tag, "_rd_addr"},  64'(rd_addr),  64'(mk_addr(3, 0)));
      chk({tag, "_err"},      64'(err),      64'd0);
      chk({tag, "_wr_frame"}, 64'(wr_frame), 64'd0);
      chk({tag, "_rd_frame"}, 64'(rd_frame), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nw, n;
      ev_t e;
      model_reset();
      repeat (3) step();
      chk_reset_vals("rst");
      rst = 1'b0;
      repeat (6) step();
      chk("no_req_before_init", 64'(evq.size()), 64'd0);

      // first write burst at the level boundary, fixed 10-cycle busy
      in_level = 9'd256; out_level = 9'd300; init_done = 1'b1;
      run_burst(1'b0, 300, 100, 10, k);
      chk("first_grant_wr", 64'(k), 64'd1);
      chk("first_wr_row", 64'(wr_addr), 64'(mk_addr(0, 1)));

      // both needs held: guard decides how often the writer wins
      nw = 0;
      for (int i = 0; i < 10; i++) begin
         run_burst(1'b0, 300, (i == 9) ? 300 : 100, 0, k);
         if (k == 1) nw++;
      end
      chk("starve_writes", 64'(nw), GUARD ? 64'd2 : 64'd0);

      // write frame wrap, then reads across a frame
      for (int i = 0; i < 3; i++) run_burst(1'b0, (i == 2) ? 0 : 300, (i == 2) ? 100 : 300, 0, k);
      for (int i = 0; i < 3; i++) run_burst(1'b0, (i == 2) ? 300 : 0, (i == 2) ? 300 : 100, 0, k);

      // busy never rises, then normal recovery
      run_burst(1'b1, 300, 300, 0, k);
      run_burst(1'b0, 0, 100, 0, k);
      run_burst(1'b0, pick_lvl(), pick_lvl(), 0, k);

      for (int i = 0; i < 40; i++)
         run_burst(1'b0, (i == 39) ? 0 : pick_lvl(), (i == 39) ? 100 : pick_lvl(), 0, k);

      // reset while waiting for read busy to fall
      decide(k);
      chk("pre_rst_grant", 64'(k), 64'd2);
      n = 0;
      while (evq.size() == 0 && n < 60) begin step(); n++; end
      chk("pre_rst_req", 64'(evq.size()), 64'd1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         chk("pre_rst_kind", 64'({e.is_wr, e.is_rd}), 64'd1);
      end
      repeat (2) step();
      rd_busy = 1'b1;
      repeat (4) step();
      #2 rst = 1'b1;
      #1 chk_reset_vals("midrst");
      rd_busy = 1'b0;
      model_reset();
      repeat (2) step();
      evq.delete();
      in_level = 9'd300; out_level = 9'd100;
      rst = 1'b0;
      run_burst(1'b0, 300, 300, 0, k);
      chk("post_rst_grant", 64'(k), 64'd2);
      for (int i = 0; i < 6; i++) run_burst(1'b0, pick_lvl(), pick_lvl(), 0, k);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
